// File: rtl/aha_ahb_sram_bridge.sv
// AHB-Lite slave bridging 32-bit bus transfers onto a 64-bit single-port SRAM.
// Reads are issued combinationally in the address phase and need no wait state.
// Writes land in the data phase. A read that arrives during a write data phase
// collides with that write on the single SRAM port and costs one wait state.
module aha_ahb_sram_bridge #(
    parameter int SRAM_AW = 12
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    output logic               SRAM_CEn,
    output logic [7:0]         SRAM_WEn,
    output logic [SRAM_AW-1:0] SRAM_A,
    output logic [63:0]        SRAM_D,
    input  logic [63:0]        SRAM_Q
);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_RDATA, S_RWAIT, S_ERR1, S_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SRAM_AW-1:0] r_addr;
    logic [2:0]         r_lo;
    logic [1:0]         r_size;

    logic               w_accept;
    logic               w_legal;
    logic               w_open;
    logic               w_capture;
    logic               w_rd_now;
    logic [7:0]         w_mask;
    logic               w_unused_ok;

    // Address and size bits beyond the window, plus HTRANS[0], are never needed.
    assign w_unused_ok = ^{HADDR[31:SRAM_AW+3], HTRANS[0]};

    assign w_accept = HSEL & HREADY & HTRANS[1];

    // Sizes above word, and addresses misaligned to their size, are illegal.
    always_comb begin
        w_legal = 1'b0;
        case (HSIZE)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~HADDR[0];
            3'd2:    w_legal = (HADDR[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // RWAIT and ERR1 hold HREADYOUT low, so only the other states take a new transfer.
    assign w_open    = (r_state != S_RWAIT) && (r_state != S_ERR1);
    assign w_capture = w_open & w_accept & w_legal;
    // A read issued straight to the SRAM, used whenever the port is free this cycle.
    assign w_rd_now  = w_capture & ~HWRITE & (r_state != S_WDATA);

    // State register and captured transfer controls.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_lo    <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr <= HADDR[SRAM_AW+2:3];
                r_lo   <= HADDR[2:0];
                r_size <= HSIZE[1:0];
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RWAIT: w_next = S_RDATA;
            S_ERR1:  w_next = S_ERR2;
            default: begin
                if (!w_accept)             w_next = S_IDLE;
                else if (!w_legal)         w_next = S_ERR1;
                else if (HWRITE)           w_next = S_WDATA;
                else if (r_state == S_WDATA) w_next = S_RWAIT;
                else                       w_next = S_RDATA;
            end
        endcase
    end

    // Byte lanes touched by the captured write; halfwords and words stay naturally aligned.
    always_comb begin
        w_mask = 8'h00;
        case (r_size)
            2'd0:    w_mask = 8'h01 << r_lo;
            2'd1:    w_mask = 8'h03 << {r_lo[2:1], 1'b0};
            default: w_mask = 8'h0F << {r_lo[2], 2'b00};
        endcase
    end

    // Bus response and SRAM port drive.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = 32'h0;
        SRAM_CEn  = 1'b1;
        SRAM_WEn  = 8'hFF;
        SRAM_A    = HADDR[SRAM_AW+2:3];
        SRAM_D    = {HWDATA, HWDATA};
        case (r_state)
            S_WDATA: begin
                SRAM_CEn = 1'b0;
                SRAM_A   = r_addr;
                SRAM_WEn = ~w_mask;
            end
            S_RDATA: HRDATA = r_lo[2] ? SRAM_Q[63:32] : SRAM_Q[31:0];
            S_RWAIT: begin
                SRAM_CEn  = 1'b0;
                SRAM_A    = r_addr;
                HREADYOUT = 1'b0;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
        if (w_rd_now) begin
            SRAM_CEn = 1'b0;
            SRAM_A   = HADDR[SRAM_AW+2:3];
        end
    end

endmodule

// File: tb/tb_aha_ahb_sram_bridge.sv
// Self-checking bench: a pipelined AHB master drives transfer lists against a
// behavioural SRAM; results are checked against a byte-addressed memory model.
module tb_aha_ahb_sram_bridge;
    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          SRAM_CEn;
    logic [7:0]    SRAM_WEn;
    logic [AW-1:0] SRAM_A;
    logic [63:0]   SRAM_D;
    logic [63:0]   SRAM_Q;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_events = 0;

    aha_ahb_sram_bridge #(.SRAM_AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    always #5 CLK = ~CLK;

    // Single slave on the bus: the bus ready is this slave's ready.
    assign HREADY = HREADYOUT;

    // Behavioural SRAM with per-byte write enables and registered read data.
    logic [63:0] sram [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (!SRAM_CEn) begin
            for (int i = 0; i < 8; i++)
                if (!SRAM_WEn[i]) sram[SRAM_A][8*i +: 8] <= SRAM_D[8*i +: 8];
            if (SRAM_WEn == 8'hFF) SRAM_Q <= sram[SRAM_A];
        end
    end

    // Count every cycle in which the SRAM sees a write.
    always @(posedge CLK)
        if (!SRAM_CEn && SRAM_WEn != 8'hFF) wr_events <= wr_events + 1;

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_mem [0:1023];

    // Transfer list consumed by run().
    bit          t_kind [64];
    bit          t_wr   [64];
    logic [31:0] t_addr [64];
    logic [2:0]  t_size [64];
    logic [31:0] t_data [64];
    int          nt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] sz, input logic [31:0] a);
        return (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic logic [7:0] exp_wen(input logic [2:0] sz, input logic [31:0] a);
        logic [7:0] m;
        m = 8'h00;
        for (int k = 0; k < (1 << sz); k++) m[(a % 8) + k] = 1'b1;
        return ~m;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < (1 << sz); k++)
            ref_mem[int'(a) + k] = d[((int'(a) + k) % 4) * 8 +: 8];
    endtask

    task automatic add(input bit kind, input bit wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] d);
        t_kind[nt] = kind; t_wr[nt] = wr; t_addr[nt] = a; t_size[nt] = sz; t_data[nt] = d;
        nt++;
    endtask

    // Wait states the protocol rules demand for transfer i of the list.
    function automatic int exp_waits(input int i);
        if (!t_kind[i]) return 0;
        if (!legal(t_size[i], t_addr[i])) return 1;
        if (!t_wr[i] && i > 0 && t_kind[i-1] && t_wr[i-1] && legal(t_size[i-1], t_addr[i-1]))
            return 1;
        return 0;
    endfunction

    task automatic drive_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd0;
    endtask

    // Issue the transfer list back to back with AHB address/data pipelining.
    task automatic run();
        int   ai, di, cyc, waits;
        logic rdy;
        bit   ok;
        ai = 0; di = -1; cyc = 0; waits = 0;
        while ((ai < nt || di >= 0) && cyc < 2000) begin
            if (ai < nt && t_kind[ai]) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = t_wr[ai];
                HADDR = t_addr[ai]; HSIZE = t_size[ai];
            end else begin
                drive_idle();
            end
            HWDATA = (di >= 0 && t_wr[di]) ? t_data[di] : 32'hDEAD_BEEF;
            @(negedge CLK);
            rdy = HREADYOUT;
            if (di >= 0) begin
                ok = legal(t_size[di], t_addr[di]);
                if (t_kind[di] && !ok) begin
                    chk("err_wen", 64'(SRAM_WEn), 64'hFF);
                    chk("err_hresp", 64'(HRESP), 64'h1);
                end
                if (!rdy) waits++;
                else begin
                    chk("waits", 64'(waits), 64'(exp_waits(di)));
                    if (!t_kind[di]) begin
                        chk("idle_hresp", 64'(HRESP), 64'h0);
                        chk("idle_hrdata", 64'(HRDATA), 64'h0);
                    end else if (ok && t_wr[di]) begin
                        chk("wr_hresp", 64'(HRESP), 64'h0);
                        chk("wr_cen", 64'(SRAM_CEn), 64'h0);
                        chk("wr_wen", 64'(SRAM_WEn), 64'(exp_wen(t_size[di], t_addr[di])));
                        chk("wr_addr", 64'(SRAM_A), 64'((t_addr[di] >> 3) % (1 << AW)));
                        ref_write(t_size[di], t_addr[di], t_data[di]);
                    end else if (ok) begin
                        chk("rd_hresp", 64'(HRESP), 64'h0);
                        chk("rd_data", 64'(HRDATA), 64'(ref_word(t_addr[di])));
                    end
                    waits = 0;
                end
            end
            @(posedge CLK); #1;
            cyc++;
            if (rdy) begin
                di = (ai < nt) ? ai : -1;
                if (ai < nt) ai++;
            end
        end
        if (cyc >= 2000) chk("run_timeout", 64'h1, 64'h0);
        drive_idle();
        nt = 0;
        @(posedge CLK); #1;
    endtask

    initial begin : main
        int w0;
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 64'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        SRAM_Q = 64'h0;
        RESET = 1'b1; HWDATA = 32'h0;
        drive_idle();
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rst_hreadyout", 64'(HREADYOUT), 64'h1);
        chk("rst_hresp", 64'(HRESP), 64'h0);
        chk("rst_hrdata", 64'(HRDATA), 64'h0);
        chk("rst_cen", 64'(SRAM_CEn), 64'h1);
        chk("rst_wen", 64'(SRAM_WEn), 64'hFF);
        @(posedge CLK); #1;

        // Word write then read at 0x104, with an idle gap between.
        add(1, 1, 32'h104, 3'd2, 32'h1234_5678);
        add(0, 0, 32'h0, 3'd0, 32'h0);
        add(1, 0, 32'h104, 3'd2, 32'h0);
        run();

        // Byte write into the top lane, then a word read of its containing word.
        add(1, 1, 32'h7, 3'd0, 32'hAB00_0000);
        add(0, 0, 32'h0, 3'd0, 32'h0);
        add(1, 0, 32'h4, 3'd2, 32'h0);
        run();

        // Read straight after write to the same word: single RWAIT, new data.
        add(1, 1, 32'h10, 3'd2, 32'hCAFE_F00D);
        add(1, 0, 32'h10, 3'd2, 32'h0);
        run();

        // Oversized and misaligned transfers.
        add(1, 1, 32'h0, 3'd3, 32'hFFFF_FFFF);
        add(1, 0, 32'h2, 3'd2, 32'h0);
        add(1, 1, 32'h2, 3'd2, 32'hFFFF_FFFF);
        add(1, 0, 32'h0, 3'd2, 32'h0);
        run();

        // Four writes then four reads, all back to back.
        for (int i = 0; i < 4; i++) add(1, 1, 32'(4 * i), 3'd2, 32'h1111_1111 * (i + 1));
        for (int i = 0; i < 4; i++) add(1, 0, 32'(4 * i), 3'd2, 32'h0);
        run();

        // Randomized mix of sizes, directions, alignments and idle gaps.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) begin
                sz = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
                a  = 32'($urandom % 256);
                if (sz <= 3'd2 && ($urandom % 5) != 0) a = a & ~((32'h1 << sz) - 1);
                add(($urandom % 6) != 0, $urandom % 2, a, sz, $urandom);
            end
            run();
        end

        // Reset while in RWAIT abandons the read.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20; HSIZE = 3'd2;
        @(posedge CLK); #1;
        HWDATA = 32'h5A5A_A5A5; HWRITE = 1'b0;
        ref_write(3'd2, 32'h20, 32'h5A5A_A5A5);
        @(posedge CLK); #1;
        drive_idle();
        RESET = 1'b1;
        @(negedge CLK);
        chk("rwait_hreadyout", 64'(HREADYOUT), 64'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rwait_hreadyout", 64'(HREADYOUT), 64'h1);
        chk("post_rwait_cen", 64'(SRAM_CEn), 64'h1);
        @(posedge CLK); #1;

        // Reset while in ERR1: no SRAM write follows.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'd3;
        @(posedge CLK); #1;
        drive_idle();
        RESET = 1'b1;
        w0 = wr_events;
        @(negedge CLK);
        chk("err1_hreadyout", 64'(HREADYOUT), 64'h0);
        chk("err1_hresp", 64'(HRESP), 64'h1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_err1_hresp", 64'(HRESP), 64'h0);
        chk("post_err1_wen", 64'(SRAM_WEn), 64'hFF);
        @(posedge CLK); #1;
        chk("post_err1_writes", 64'(wr_events), 64'(w0));

        // Confirm the write before the RWAIT reset landed.
        add(1, 0, 32'h20, 3'd2, 32'h0);
        run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
